// File: rtl/vc_fifo.sv
// Multi-channel packet FIFO. NCH independent queues of DEPTH words share one storage array.
// Each channel has wrap-bit pointers, FWFT read data, and sticky overflow/underflow flags.
module vc_fifo #(
   parameter  int W        = 32,
   parameter  int DEPTH    = 4,
   parameter  int NCH      = 2,
   parameter  int AFULL_TH = 3,
   localparam int AW       = $clog2(DEPTH),
   localparam int CW       = AW + 1,
   localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W-1:0]      in_data,
   input  logic [CHW-1:0]    in_ch,
   input  logic              we,
   input  logic [CHW-1:0]    rd_ch,
   input  logic              re,
   output logic [W-1:0]      out_data,
   output logic [NCH-1:0]    full,
   output logic [NCH-1:0]    afull,
   output logic [NCH-1:0]    empty,
   output logic [NCH*CW-1:0] count,
   output logic [NCH-1:0]    ovf,
   output logic [NCH-1:0]    udf
);

   logic [CW-1:0]       r_head [NCH];
   logic [CW-1:0]       r_tail [NCH];
   logic [W-1:0]        r_mem  [NCH*DEPTH];
   logic [NCH-1:0]      r_ovf;
   logic [NCH-1:0]      r_udf;

   logic [CW-1:0]       w_cnt  [NCH];
   logic [NCH-1:0]      w_wr_en;
   logic [NCH-1:0]      w_rd_en;
   logic [NCH-1:0]      w_ovf_set;
   logic [NCH-1:0]      w_udf_set;
   logic [AW-1:0]       w_wr_ptr;
   logic [AW-1:0]       w_rd_ptr;
   logic                w_rd_hit;
   logic [CHW+AW-1:0]   w_wr_addr;
   logic [CHW+AW-1:0]   w_rd_addr;

   // Status flags come straight from the registered pointers; the MSB is the wrap bit.
   always_comb begin
      full  = '0;
      afull = '0;
      empty = '0;
      count = '0;
      for (int c = 0; c < NCH; c++) begin
         w_cnt[c]            = r_head[c] - r_tail[c];
         empty[c]            = (r_head[c] == r_tail[c]);
         full[c]             = (r_head[c][AW-1:0] == r_tail[c][AW-1:0]) &&
                               (r_head[c][AW] != r_tail[c][AW]);
         afull[c]            = (w_cnt[c] >= CW'(AFULL_TH));
         count[c*CW +: CW]   = w_cnt[c];
      end
   end

   // A channel number with no matching c selects nothing, so out-of-range requests are inert.
   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      w_wr_en   = '0;
      w_rd_en   = '0;
      w_ovf_set = '0;
      w_udf_set = '0;
      w_wr_ptr  = '0;
      w_rd_ptr  = '0;
      w_rd_hit  = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (in_ch == CHW'(c)) begin
            w_wr_ptr     = r_head[c][AW-1:0];
            w_wr_en[c]   = we && !full[c];
            w_ovf_set[c] = we && full[c];
         end
         if (rd_ch == CHW'(c)) begin
            w_rd_ptr     = r_tail[c][AW-1:0];
            w_rd_hit     = !empty[c];
            w_rd_en[c]   = re && !empty[c];
            w_udf_set[c] = re && empty[c];
         end
      end
   end

   assign w_wr_addr = {in_ch, w_wr_ptr};
   assign w_rd_addr = {rd_ch, w_rd_ptr};
   assign out_data  = w_rd_hit ? r_mem[w_rd_addr] : '0;
   assign ovf       = r_ovf;
   assign udf       = r_udf;

   // NOTE: storage has no reset; the pointers alone define which words are valid.
   always_ff @(posedge clk) begin
      if (!rst && (|w_wr_en))
         r_mem[w_wr_addr] <= in_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            r_head[c] <= '0;
            r_tail[c] <= '0;
         end
         r_ovf <= '0;
         r_udf <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (w_wr_en[c])
               r_head[c] <= r_head[c] + 1'b1;
            if (w_rd_en[c])
               r_tail[c] <= r_tail[c] + 1'b1;
         end
         r_ovf <= r_ovf | w_ovf_set;
         r_udf <= r_udf | w_udf_set;
      end
   end

endmodule

// File: tb/tb_vc_fifo.sv
// Directed bench for vc_fifo (W=32, DEPTH=4, NCH=2, AFULL_TH=3).
// Expected values are hand-computed constants.
module tb_vc_fifo;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        in_ch;
   logic        we;
   logic        rd_ch;
   logic        re;
   logic [31:0] out_data;
   logic [1:0]  full;
   logic [1:0]  afull;
   logic [1:0]  empty;
   logic [5:0]  count;
   logic [1:0]  ovf;
   logic [1:0]  udf;

   int n_tests = 0;
   int n_fail  = 0;

   vc_fifo #(.W(32), .DEPTH(4), .NCH(2), .AFULL_TH(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_ch    (in_ch),
      .we       (we),
      .rd_ch    (rd_ch),
      .re       (re),
      .out_data (out_data),
      .full     (full),
      .afull    (afull),
      .empty    (empty),
      .count    (count),
      .ovf      (ovf),
      .udf      (udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic ch, input logic [31:0] d);
      we = 1'b1; in_ch = ch; in_data = d;
      step();
      we = 1'b0;
   endtask

   task automatic rd(input logic ch);
      rd_ch = ch; re = 1'b1;
      step();
      re = 1'b0;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; re = 1'b0; in_ch = 1'b0; rd_ch = 1'b0; in_data = '0;
      step();
      step();
      rst = 1'b0;
      step();

      // Reset state
      check("rst_empty", 32'(empty), 32'h3);
      check("rst_full",  32'(full),  32'h0);
      check("rst_afull", 32'(afull), 32'h0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_out",   out_data,   32'h0);
      check("rst_ovf",   32'(ovf),   32'h0);
      check("rst_udf",   32'(udf),   32'h0);

      // Fill ch0 and drain it in order
      wr(1'b0, 32'hA1);
      wr(1'b0, 32'hA2);
      check("afull_at2", 32'(afull[0]), 32'h0);
      wr(1'b0, 32'hA3);
      check("afull_at3", 32'(afull[0]), 32'h1);
      check("full_at3",  32'(full[0]),  32'h0);
      wr(1'b0, 32'hA4);
      check("full_at4",  32'(full[0]),  32'h1);
      check("cnt0_at4",  32'(count[2:0]), 32'h4);
      check("empty1_at4", 32'(empty[1]), 32'h1);
      rd_ch = 1'b0;
      #1;
      check("pop_a1", out_data, 32'hA1);
      rd(1'b0);
      check("pop_a2", out_data, 32'hA2);
      rd(1'b0);
      check("pop_a3", out_data, 32'hA3);
      rd(1'b0);
      check("pop_a4", out_data, 32'hA4);
      rd(1'b0);
      check("drain_empty0", 32'(empty[0]), 32'h1);
      check("drain_out",    out_data,      32'h0);

      // Overflow on full ch0, then underflow on empty ch1
      wr(1'b0, 32'hB0);
      wr(1'b0, 32'hB1);
      wr(1'b0, 32'hB2);
      wr(1'b0, 32'hB3);
      wr(1'b0, 32'hFF);
      check("ovf_set",   32'(ovf),        32'h1);
      check("ovf_cnt0",  32'(count[2:0]), 32'h4);
      check("ovf_head",  out_data,        32'hB0);
      rd(1'b1);
      check("udf_set",   32'(udf),        32'h2);
      check("udf_cnt0",  32'(count[2:0]), 32'h4);
      rd_ch = 1'b0;
      #1;
      check("udf_head0", out_data, 32'hB0);
      for (int i = 0; i < 4; i++) begin
         check("ovf_drain", out_data, 32'hB0 + 32'(i));
         rd(1'b0);
      end
      check("ovf_drained", 32'(empty), 32'h3);

      // Interleaved channels; out_data follows rd_ch combinationally
      wr(1'b0, 32'h11);
      wr(1'b1, 32'h22);
      rd_ch = 1'b1;
      #1;
      check("mux_ch1", out_data, 32'h22);
      rd_ch = 1'b0;
      #1;
      check("mux_ch0", out_data, 32'h11);
      check("il_cnt0", 32'(count[2:0]), 32'h1);
      check("il_cnt1", 32'(count[5:3]), 32'h1);
      rd(1'b0);
      rd(1'b1);
      check("il_empty", 32'(empty), 32'h3);

      // Same-channel read+write while full: read wins, write dropped
      wr(1'b1, 32'hC1);
      wr(1'b1, 32'hC2);
      wr(1'b1, 32'hC3);
      wr(1'b1, 32'hC4);
      we = 1'b1; in_ch = 1'b1; in_data = 32'hDD; re = 1'b1; rd_ch = 1'b1;
      step();
      we = 1'b0; re = 1'b0;
      check("fullrw_ovf",  32'(ovf[1]),    32'h1);
      check("fullrw_cnt1", 32'(count[5:3]), 32'h3);
      check("fullrw_head", out_data,        32'hC2);

      // Same-channel read+write while empty: write wins, read flags underflow
      we = 1'b1; in_ch = 1'b0; in_data = 32'h55; re = 1'b1; rd_ch = 1'b0;
      step();
      we = 1'b0; re = 1'b0;
      check("emptyrw_cnt0", 32'(count[2:0]), 32'h1);
      check("emptyrw_udf",  32'(udf[0]),     32'h1);
      check("emptyrw_out",  out_data,        32'h55);
      rd(1'b0);
      rd_ch = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("fullrw_drain", out_data, 32'hC2 + 32'(i));
         rd(1'b1);
      end
      check("fullrw_empty1", 32'(empty[1]), 32'h1);

      // Pointer wrap on ch0 with write/read pairs
      for (int i = 0; i < 10; i++) begin
         wr(1'b0, 32'h300 + 32'(i));
         rd_ch = 1'b0;
         #1;
         check("wrap_data", out_data, 32'h300 + 32'(i));
         rd(1'b0);
      end
      check("wrap_cnt0",  32'(count[2:0]), 32'h0);
      check("wrap_empty", 32'(empty[0]),   32'h1);

      // Reset with traffic in flight
      wr(1'b1, 32'hE1);
      wr(1'b1, 32'hE2);
      check("pre_rst_cnt1", 32'(count[5:3]), 32'h2);
      rst = 1'b1; we = 1'b1; in_ch = 1'b0; in_data = 32'h77; re = 1'b1; rd_ch = 1'b1;
      step();
      rst = 1'b0; we = 1'b0; re = 1'b0;
      check("mid_rst_empty", 32'(empty), 32'h3);
      check("mid_rst_count", 32'(count), 32'h0);
      check("mid_rst_ovf",   32'(ovf),   32'h0);
      check("mid_rst_udf",   32'(udf),   32'h0);
      check("mid_rst_out",   out_data,   32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
- Multi-channel (virtual-channel) packet FIFO for switch input/output buffering.
- Holds NCH independent queues of DEPTH words each in one shared storage array, partitioned by channel.
- One write port tagged with a channel number; one read port with a separately selected channel.
- Generational changes: every queue holds a full DEPTH words (extra pointer wrap bit); writes to storage happen only when accepted; adds per-channel almost-full, occupancy counts and sticky overflow/underflow flags.

Parameters:
W, 32, data word width in bits (packet word incl. header bits)
DEPTH, 4, words per channel; power of two, >= 2
NCH, 2, number of channels; >= 1
AFULL_TH, 3, almost-full asserts when count >= AFULL_TH (1..DEPTH)
Derived: AW = log2(DEPTH); CW = AW+1; CHW = max(1, log2(NCH))

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_data  in  W  write data
in_ch  in  CHW  write channel select
we  in  1  write request
rd_ch  in  CHW  read channel select
re  in  1  read request (pop)
out_data  out  W  head word of channel rd_ch; 0 when that channel is empty
full  out  NCH  bit c = channel c holds DEPTH words
afull  out  NCH  bit c = count[c] >= AFULL_TH
empty  out  NCH  bit c = channel c holds 0 words
count  out  NCH*CW  occupancy; channel c in bits [c*CW +: CW]
ovf  out  NCH  sticky: write attempted to full channel c
udf  out  NCH  sticky: read attempted from empty channel c

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. When rst is sampled high at a posedge, all head/tail pointers, ovf and udf are cleared. After that edge: empty = all ones, full = 0, afull = 0, count = 0, out_data = 0. Storage contents are not reset. rst has priority over we/re in the same cycle.
- Pointers: per channel, head[c] and tail[c] are CW bits wide; the MSB is the wrap bit. Storage address = c*DEPTH + ptr[AW-1:0]; total storage is NCH*DEPTH words.
- Flags, combinational from registered pointers:
  - empty[c]: head == tail.
  - full[c]: low AW bits equal and MSBs differ.
  - count[c] = head - tail, modulo 2^CW.
- Write accepted iff we && !full[in_ch]:
  - mem[in_ch*DEPTH + head[low]] <= in_data; head[in_ch] increments.
  - Storage is never written on a rejected write.
- Read accepted iff re && !empty[rd_ch]: tail[rd_ch] increments.
- Read data path: combinational first-word-fall-through. out_data = mem[rd_ch*DEPTH + tail[low]] when !empty[rd_ch], else 0. out_data follows rd_ch changes in the same cycle. A word written at edge N is visible on out_data after edge N (no bypass in the write cycle).
- Write latency into the visible head: 1 cycle. Flag and count update: the cycle after the accepting edge.
- Simultaneous read and write, different channels: both proceed independently.
- Simultaneous read and write, same channel, neither empty nor full: both accepted; count unchanged; full/empty unchanged.
- Simultaneous read and write, same channel, full: read accepted; write rejected (full is evaluated on pre-edge state); ovf set.
- Simultaneous read and write, same channel, empty: write accepted; read rejected; udf set.
- Overflow: we && full[in_ch] sets ovf[in_ch] at the edge; data is dropped; pointers are unchanged.
- Underflow: re && empty[rd_ch] sets udf[rd_ch]; pointers are unchanged. ovf and udf hold until rst.
- Wrap-around: pointers roll over modulo 2^CW with no special case. Channel partitions never alias.
- in_ch and rd_ch values >= NCH (non-power-of-two NCH):
  - A write is ignored and flags nothing.
  - A read is ignored.
  - out_data = 0.
- Reset mid-operation: all queues empty after the reset edge, regardless of in-flight we/re.

Test Plan:
- Reset, then idle -> empty = 2'b11, full = 0, afull = 0, count = 0, out_data = 0, ovf = udf = 0.
- DEPTH=4: write 0xA1, 0xA2, 0xA3, 0xA4 to ch0, then read ch0 ×4 -> out_data = A1, A2, A3, A4 in order. After the 3rd write afull[0] = 1; after the 4th full[0] = 1, count0 = 4. After the reads empty[0] = 1 and out_data = 0.
- Fill ch0 (4 words), write 0xFF to ch0 -> ovf[0] = 1, count0 stays 4, queue contents unchanged. Then re on empty ch1 -> udf[1] = 1; ch0 unaffected.
- Interleave: write 0x11 to ch0 and 0x22 to ch1. Set rd_ch = 1 -> out_data = 0x22 the same cycle. Set rd_ch = 0 -> out_data = 0x11. count0 = count1 = 1.
- Full ch1 plus simultaneous we/re on ch1 -> read pops the oldest word; write rejected; ovf[1] = 1; count1 = 3. Empty ch0 plus simultaneous we/re with 0x55 -> count0 = 1; udf[0] = 1; out_data = 0x55 next cycle.
- Wrap: run 10 write/read pairs on ch0 (pointers wrap twice) -> data order preserved; count0 returns to 0. Assert rst while ch1 holds 2 words -> all empty, count1 = 0 the next cycle.
